// File: rtl/tx_cp_insert.sv
// Ping-pong symbol buffer that replays each IFFT symbol with its cyclic prefix.
// Define TXCP_INDEX_CHECK_EN to check Data_in_index against wptr (IndexErr).
module tx_cp_insert #(
  parameter int DW      = 8,
  parameter int NFFT    = 64,
  parameter int CP_DATA = 16,
  parameter int CP_LTS  = 32,
  localparam int AW     = $clog2(NFFT),
  localparam int OW     = $clog2(NFFT + CP_LTS)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          DataInEnable,
  output logic          DataInReady,
  input  logic [DW-1:0] DataInRe,
  input  logic [DW-1:0] DataInIm,
  input  logic [AW-1:0] Data_in_index,
  input  logic          FrameStart,
  input  logic          FrameLast,
  output logic          DataOutEnable,
  output logic [DW-1:0] DataOutRe,
  output logic [DW-1:0] DataOutIm,
  output logic [OW-1:0] Data_out_index,
  output logic [7:0]    Symbol_cnt,
`ifdef TXCP_INDEX_CHECK_EN
  output logic          IndexErr,
`endif
  output logic          DataOutLast
);

  typedef enum logic [1:0] {
    IDLE,
    CP,
    BODY
  } st_e;

  logic [2*DW-1:0] mem [2*NFFT];

  logic          wbank_q, wbank_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] waddr;
  logic [1:0]    full_q, full_d;
  logic [1:0]    lts_q, lts_d;
  logic [1:0]    last_q, last_d;
  logic          clts_q, clts_d;
  logic          clast_q, clast_d;
  logic          acc, rel;

  st_e           state_q;
  logic          rbank_q;
  logic [AW-1:0] raddr_q;
  logic [OW-1:0] oidx_q;

  function automatic logic [AW-1:0] cp_start(
    input logic lts
  );
    return lts ? AW'(NFFT - CP_LTS)
               : AW'(NFFT - CP_DATA);
  endfunction

  assign acc = DataInEnable && DataInReady;
  assign rel = (state_q == BODY) && (&raddr_q);

`ifdef TXCP_INDEX_CHECK_EN
  logic err_d;

  always_comb begin
    waddr = wptr_q;
    err_d = IndexErr;
    if (acc) begin
      if (FrameStart) begin
        waddr = '0;
        err_d = 1'b0;
      end else if (Data_in_index != wptr_q) begin
        waddr = Data_in_index;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) IndexErr <= 1'b0;
    else        IndexErr <= err_d;
  end
`else
  logic idx_unused;
  assign idx_unused = ^Data_in_index;
  assign waddr = FrameStart ? '0 : wptr_q;
`endif

  // Release wins over a refill; the refill sees ready one cycle later.
  always_comb begin
    full_d  = full_q;
    lts_d   = lts_q;
    last_d  = last_q;
    wbank_d = wbank_q;
    wptr_d  = wptr_q;
    clts_d  = clts_q;
    clast_d = clast_q;
    if (rel) full_d[rbank_q] = 1'b0;
    if (acc) begin
      wptr_d  = waddr + 1'b1;
      clts_d  = (waddr == '0) ? FrameStart : clts_q;
      clast_d = (waddr == '0) ? FrameLast
                              : (clast_q | FrameLast);
      if (&waddr) begin
        full_d[wbank_q] = 1'b1;
        lts_d[wbank_q]  = clts_d;
        last_d[wbank_q] = clast_d;
        wbank_d         = ~wbank_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wbank_q     <= 1'b0;
      wptr_q      <= '0;
      full_q      <= '0;
      lts_q       <= '0;
      last_q      <= '0;
      clts_q      <= 1'b0;
      clast_q     <= 1'b0;
      DataInReady <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      wptr_q      <= wptr_d;
      full_q      <= full_d;
      lts_q       <= lts_d;
      last_q      <= last_d;
      clts_q      <= clts_d;
      clast_q     <= clast_d;
      DataInReady <= !full_d[wbank_d];
    end
  end

  always_ff @(posedge Clk) begin
    if (acc) mem[{wbank_q, waddr}] <= {DataInRe, DataInIm};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= IDLE;
      rbank_q        <= 1'b0;
      raddr_q        <= '0;
      oidx_q         <= '0;
      DataOutEnable  <= 1'b0;
      DataOutRe      <= '0;
      DataOutIm      <= '0;
      Data_out_index <= '0;
      Symbol_cnt     <= '0;
      DataOutLast    <= 1'b0;
    end else begin
      DataOutEnable  <= (state_q != IDLE);
      DataOutRe      <= '0;
      DataOutIm      <= '0;
      Data_out_index <= '0;
      DataOutLast    <= 1'b0;
      if (state_q != IDLE) begin
        {DataOutRe, DataOutIm} <= mem[{rbank_q, raddr_q}];
        Data_out_index <= oidx_q;
        DataOutLast    <= rel && last_q[rbank_q];
        if (state_q == CP && oidx_q == '0)
          Symbol_cnt <= lts_q[rbank_q] ? '0
                                       : Symbol_cnt + 1'b1;
        raddr_q <= raddr_q + 1'b1;
        oidx_q  <= oidx_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (full_d[rbank_q]) begin
            state_q <= CP;
            raddr_q <= cp_start(lts_d[rbank_q]);
            oidx_q  <= '0;
          end
        end
        CP: begin
          if (&raddr_q) state_q <= BODY;
        end
        BODY: begin
          if (&raddr_q) begin
            rbank_q <= ~rbank_q;
            if (full_d[~rbank_q]) begin
              state_q <= CP;
              raddr_q <= cp_start(lts_d[~rbank_q]);
              oidx_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_cp_insert.sv
// Randomized bench for tx_cp_insert against a queue-based
// model of the expected CP-prefixed output stream.
module tb_tx_cp_insert;

  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          DataInEnable = 1'b0;
  logic          DataInReady;
  logic [DW-1:0] DataInRe = '0;
  logic [DW-1:0] DataInIm = '0;
  logic [5:0]    Data_in_index = '0;
  logic          FrameStart = 1'b0;
  logic          FrameLast = 1'b0;
  logic          DataOutEnable;
  logic [DW-1:0] DataOutRe;
  logic [DW-1:0] DataOutIm;
  logic [6:0]    Data_out_index;
  logic [7:0]    Symbol_cnt;
  logic          DataOutLast;
`ifdef TXCP_INDEX_CHECK_EN
  logic          IndexErr;
`endif

  tx_cp_insert dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .DataInEnable  (DataInEnable),
    .DataInReady   (DataInReady),
    .DataInRe      (DataInRe),
    .DataInIm      (DataInIm),
    .Data_in_index (Data_in_index),
    .FrameStart    (FrameStart),
    .FrameLast     (FrameLast),
    .DataOutEnable (DataOutEnable),
    .DataOutRe     (DataOutRe),
    .DataOutIm     (DataOutIm),
    .Data_out_index(Data_out_index),
    .Symbol_cnt    (Symbol_cnt),
`ifdef TXCP_INDEX_CHECK_EN
    .IndexErr      (IndexErr),
`endif
    .DataOutLast   (DataOutLast)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] d;
    logic [6:0]  idx;
    logic [7:0]  sc;
    logic        last;
  } exp_t;

  exp_t        expq[$];
  int          acc63[$];
  logic [15:0] sym[64];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int msym = 0;
  int n_acc = 0;
  int gap_cnt = 0;
  bit started = 0;
  int rise_cyc = -1;
  bit prev_en = 0;
  bit prev_rdy = 0;
  bit bp_arm = 0;
  int fall_acc = -1;
  int rdy_back = -1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Expected stream: tail of the symbol as CP, then the whole symbol.
  task automatic model_sym(input bit lts, input bit last);
    int   cp;
    exp_t e;
    cp   = lts ? 32 : 16;
    msym = lts ? 0 : (msym + 1) % 256;
    for (int k = 0; k < cp + 64; k++) begin
      e.d    = (k < cp) ? sym[64 - cp + k] : sym[k - cp];
      e.idx  = 7'(k);
      e.sc   = 8'(msym);
      e.last = last && (k == cp + 63);
      expq.push_back(e);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (DataOutEnable && !prev_en && rise_cyc < 0)
        rise_cyc = cyc;
      if (started && !DataOutEnable && expq.size() != 0)
        gap_cnt++;
      if (DataOutEnable) begin
        started = 1;
        if (expq.size() == 0) begin
          chk("spurious_out", 32'(Data_out_index), 32'h7f);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("data", 32'({DataOutRe, DataOutIm}), 32'(e.d));
          chk("out_idx", 32'(Data_out_index), 32'(e.idx));
          chk("sym_cnt", 32'(Symbol_cnt), 32'(e.sc));
          chk("out_last", 32'(DataOutLast), 32'(e.last));
        end
      end else begin
        chk("idle_zero", 32'({DataOutRe, DataOutIm,
            Data_out_index, DataOutLast}), 0);
      end
      prev_en = DataOutEnable;
      if (bp_arm) begin
        if (prev_rdy && !DataInReady && fall_acc < 0)
          fall_acc = n_acc;
        if (!prev_rdy && DataInReady && fall_acc >= 0 && rdy_back < 0)
          rdy_back = cyc;
      end
    end
    prev_rdy = DataInReady;
  end

  // Entered and left at posedge+1; n < 64 sends a partial symbol.
  task automatic send_sym(input bit fs, input bit fl,
                          input int n, input bit swp);
    int j;
    j = $urandom_range(0, 63);
    for (int i = 0; i < 64; i++) sym[i] = 16'($urandom);
    if (n == 64) model_sym(fs, fl);
    for (int i = 0; i < n; i++) begin
      int w;
      int k;
      w = 0;
      k = (swp && i == 11) ? 12 : (swp && i == 12) ? 11 : i;
      DataInEnable = 1'b1;
      {DataInRe, DataInIm} = sym[k];
      Data_in_index = 6'(k);
      FrameStart = fs && (i == 0);
      FrameLast = fl && (i == j);
      forever begin
        @(negedge Clk);
        if (DataInReady) break;
        w++;
        if (w > 400) begin
          chk("stall_timeout", 32'(w), 0);
          break;
        end
      end
      n_acc++;
      if (i == 63) acc63.push_back(cyc);
      @(posedge Clk);
      #1;
    end
    DataInEnable = 1'b0;
    FrameStart = 1'b0;
    FrameLast = 1'b0;
  endtask

  task automatic idle(input int n);
    DataInEnable = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (expq.size() != 0 && w < 3000) begin
      @(negedge Clk);
      w++;
    end
    chk("drain", 32'(expq.size()), 0);
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rdy_rel0", 32'(DataInReady), 0);
    @(negedge Clk);
    chk("rdy_rel1", 32'(DataInReady), 1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ctl", 32'({DataOutEnable, DataInReady,
        DataOutLast}), 0);
    chk("rst_dat", 32'({DataOutRe, DataOutIm,
        Data_out_index, Symbol_cnt}), 0);
    release_rst();

    // Lone LTS from idle: latency and CP of 32
    rise_cyc = -1;
    acc63.delete();
    send_sym(1, 0, 64, 0);
    drain();
    chk("lts_latency", 32'(rise_cyc - acc63[0]), 2);

    // LTS + 3 data symbols streamed back to back
    started = 0;
    gap_cnt = 0;
    send_sym(1, 0, 64, 0);
    send_sym(0, 0, 64, 0);
    send_sym(0, 0, 64, 0);
    send_sym(0, 1, 64, 0);
    drain();
    chk("no_gap", 32'(gap_cnt), 0);

    // Backpressure with input valid held high
    n_acc = 0;
    fall_acc = -1;
    rdy_back = -1;
    acc63.delete();
    bp_arm = 1;
    send_sym(1, 0, 64, 0);
    send_sym(0, 0, 64, 0);
    send_sym(0, 0, 64, 0);
    send_sym(0, 0, 64, 0);
    drain();
    bp_arm = 0;
    chk("bp_fall_cnt", 32'(fall_acc), 128);
    chk("bp_rdy_back", 32'(rdy_back),
        32'(acc63[0] + 1 + 32 + 63 + 1));

    // Underrun: input gap between symbols
    started = 0;
    gap_cnt = 0;
    send_sym(0, 0, 64, 0);
    idle(20);
    send_sym(0, 1, 64, 0);
    drain();
    chk("underrun_seen", 32'(gap_cnt > 0), 1);

    // FrameStart mid-symbol discards the partial symbol
    send_sym(0, 0, 20, 0);
    send_sym(1, 1, 64, 0);
    drain();

    // Reset at output sample 40 of a data symbol
    send_sym(1, 0, 64, 0);
    send_sym(0, 0, 64, 0);
    w = 0;
    do begin
      @(negedge Clk);
      w++;
    end while (!(DataOutEnable && Data_out_index == 7'd40 &&
                 32'(Symbol_cnt) == msym) && w < 1000);
    chk("rst_wait", 32'(w < 1000), 1);
    #1 Rst_n = 1'b0;
    #1;
    expq.delete();
    chk("midrst_ctl", 32'({DataOutEnable, DataInReady,
        DataOutLast}), 0);
    chk("midrst_dat", 32'({DataOutRe, DataOutIm,
        Data_out_index, Symbol_cnt}), 0);
    repeat (2) @(posedge Clk);
    release_rst();
    send_sym(1, 0, 64, 0);
    send_sym(0, 1, 64, 0);
    drain();

`ifdef TXCP_INDEX_CHECK_EN
    send_sym(0, 0, 64, 1);
    chk("idx_err_set", 32'(IndexErr), 1);
    drain();
    send_sym(1, 0, 64, 0);
    chk("idx_err_clr", 32'(IndexErr), 0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
